// File: rtl/writeback_arbiter_pkg.sv
// rtl/writeback_arbiter_pkg.sv - shared widths for the register-file writeback path
//
// Purpose: common datapath/register-index widths and the hardwired-zero
//          register index used by the writeback arbiter and its FIFO.
// Ports:   none (package).
package writeback_arbiter_pkg;

   localparam int XLEN   = 32;
   localparam int REG_AW = 5;
   localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - memory-result FIFO with per-entry destination visibility
//
// Purpose: holds memory/load results until the register-file port is free.
//          Exposes every slot's rd plus a valid mask so the top can answer
//          hazard queries against all in-flight entries.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   push, push_rd/_data   enqueue request (ignored while full)
//   pop                   dequeue request (ignored while empty)
//   full, empty, count    occupancy status, count runs 0..DEPTH
//   head_rd, head_data    oldest entry
//   ent_valid, ent_rd     per-slot valid mask and packed rd fields
module wb_fifo
   import writeback_arbiter_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [REG_AW-1:0]        push_rd,
   input  logic [XLEN-1:0]          push_data,
   input  logic                     pop,
   output logic                     full,
   output logic                     empty,
   output logic [AW:0]              count,
   output logic [REG_AW-1:0]        head_rd,
   output logic [XLEN-1:0]          head_data,
   output logic [DEPTH-1:0]         ent_valid,
   output logic [DEPTH*REG_AW-1:0]  ent_rd
);

   logic [REG_AW-1:0] rd_mem   [DEPTH];
   logic [XLEN-1:0]   data_mem [DEPTH];
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [AW:0]       count_q,  count_d;
   logic              push_ok;
   logic              pop_ok;

   assign full    = (count_q == (AW+1)'(DEPTH));
   assign empty   = (count_q == '0);
   assign count   = count_q;
   // Full is judged on the registered count, so a same-cycle pop never frees room.
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;

   assign head_rd   = rd_mem[rd_ptr_q];
   assign head_data = data_mem[rd_ptr_q];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: a slot is only observed once the valid mask covers it.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         rd_mem[wr_ptr_q]   <= push_rd;
         data_mem[wr_ptr_q] <= push_data;
      end
   end

   // A slot is live when its distance from the read pointer is below the count.
   always_comb begin
      ent_valid = '0;
      ent_rd    = '0;
      for (int i = 0; i < DEPTH; i++) begin
         logic [AW-1:0] offset;
         offset       = AW'(i) - rd_ptr_q;
         ent_valid[i] = ({1'b0, offset} < count_q);
         ent_rd[i*REG_AW +: REG_AW] = rd_mem[i];
      end
   end

endmodule

// File: rtl/writeback_arbiter.sv
// rtl/writeback_arbiter.sv - single register-file write port shared by ALU and memory results
//
// Purpose: ALU results always win the port and are never stalled; memory results
//          queue in wb_fifo and drain on cycles without an ALU result. Also
//          answers whether a register still has an unwritten result in flight.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   alu_valid, alu_rd, alu_data     ALU result (no backpressure)
//   mem_valid, mem_ready,
//   mem_rd, mem_data                memory result handshake
//   query_reg, query_pending        combinational hazard query
//   fifo_count                      queued memory results
//   write_enable, write_reg,
//   write_data                      registered write port to registerFile
module writeback_arbiter
   import writeback_arbiter_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              alu_valid,
   input  logic [REG_AW-1:0] alu_rd,
   input  logic [XLEN-1:0]   alu_data,
   input  logic              mem_valid,
   output logic              mem_ready,
   input  logic [REG_AW-1:0] mem_rd,
   input  logic [XLEN-1:0]   mem_data,
   input  logic [REG_AW-1:0] query_reg,
   output logic              query_pending,
   output logic [AW:0]       fifo_count,
   output logic              write_enable,
   output logic [REG_AW-1:0] write_reg,
   output logic [XLEN-1:0]   write_data
);

   logic                     full;
   logic                     empty;
   logic                     push;
   logic                     pop;
   logic [REG_AW-1:0]        head_rd;
   logic [XLEN-1:0]          head_data;
   logic [DEPTH-1:0]         ent_valid;
   logic [DEPTH*REG_AW-1:0]  ent_rd;

   logic                     we_q, we_d;
   logic [REG_AW-1:0]        wr_q, wr_d;
   logic [XLEN-1:0]          wd_q, wd_d;

   assign mem_ready = !full;
   // Results for x0 complete the handshake but are dropped rather than queued.
   assign push = mem_valid && (mem_rd != REG_ZERO);
   // Any ALU result, even one targeting x0, owns the port for this cycle.
   assign pop  = !alu_valid && !empty;

   wb_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_rd   (mem_rd),
      .push_data (mem_data),
      .pop       (pop),
      .full      (full),
      .empty     (empty),
      .count     (fifo_count),
      .head_rd   (head_rd),
      .head_data (head_data),
      .ent_valid (ent_valid),
      .ent_rd    (ent_rd)
   );

   always_comb begin
      we_d = 1'b0;
      wr_d = wr_q;
      wd_d = wd_q;
      if (alu_valid) begin
         we_d = (alu_rd != REG_ZERO);
         wr_d = alu_rd;
         wd_d = alu_data;
      end else if (!empty) begin
         we_d = 1'b1;
         wr_d = head_rd;
         wd_d = head_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         we_q <= 1'b0;
         wr_q <= '0;
         wd_q <= '0;
      end else begin
         we_q <= we_d;
         wr_q <= wr_d;
         wd_q <= wd_d;
      end
   end

   assign write_enable = we_q;
   assign write_reg    = wr_q;
   assign write_data   = wd_q;

   // The output register counts as in flight until registerFile commits it.
   always_comb begin
      query_pending = 1'b0;
      if (query_reg != REG_ZERO) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (ent_valid[i] && (ent_rd[i*REG_AW +: REG_AW] == query_reg))
               query_pending = 1'b1;
         end
         if (we_q && (wr_q == query_reg))
            query_pending = 1'b1;
      end
   end

endmodule

// File: tb/tb_writeback_arbiter.sv
// tb/tb_writeback_arbiter.sv - randomized and directed bench for writeback_arbiter
module tb_writeback_arbiter;

   localparam int DEPTH = 4;
   localparam int AW    = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        alu_valid;
   logic [4:0]  alu_rd;
   logic [31:0] alu_data;
   logic        mem_valid;
   logic        mem_ready;
   logic [4:0]  mem_rd;
   logic [31:0] mem_data;
   logic [4:0]  query_reg;
   logic        query_pending;
   logic [AW:0] fifo_count;
   logic        write_enable;
   logic [4:0]  write_reg;
   logic [31:0] write_data;

   writeback_arbiter #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk           (clk),
      .reset         (reset),
      .alu_valid     (alu_valid),
      .alu_rd        (alu_rd),
      .alu_data      (alu_data),
      .mem_valid     (mem_valid),
      .mem_ready     (mem_ready),
      .mem_rd        (mem_rd),
      .mem_data      (mem_data),
      .query_reg     (query_reg),
      .query_pending (query_pending),
      .fifo_count    (fifo_count),
      .write_enable  (write_enable),
      .write_reg     (write_reg),
      .write_data    (write_data)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference model: FIFO as queues, write port as three plain variables.
   logic [4:0]  m_rd[$];
   logic [31:0] m_d[$];
   logic        m_we = 1'b0;
   logic [4:0]  m_wr = '0;
   logic [31:0] m_wd = '0;

   // Register file as written by the DUT's port, plus the DUT's write order.
   logic [31:0] dut_rf [32];
   logic [4:0]  wlog[$];
   int          force_q = -1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic m_pending(input logic [4:0] r);
      if (r == 5'd0) return 1'b0;
      foreach (m_rd[i]) if (m_rd[i] == r) return 1'b1;
      return m_we && (m_wr == r);
   endfunction

   task automatic step(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                       input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                       input logic rst);
      logic        pre_we;
      logic [4:0]  pre_wr;
      logic [31:0] pre_wd;
      logic        full;
      @(negedge clk);
      reset = rst; alu_valid = av; alu_rd = ard; alu_data = ad;
      mem_valid = mv; mem_rd = mrd; mem_data = md;
      if (force_q >= 0)
         query_reg = force_q[4:0];
      else if (m_rd.size() > 0 && $urandom_range(0, 1) == 1)
         query_reg = m_rd[$urandom_range(0, m_rd.size() - 1)];
      else
         query_reg = 5'($urandom_range(0, 31));
      #1;
      full = (m_rd.size() == DEPTH);
      check("mem_ready", mem_ready, !full);
      check("query_pending", query_pending, m_pending(query_reg));
      pre_we = write_enable; pre_wr = write_reg; pre_wd = write_data;
      @(posedge clk);
      if (pre_we) begin
         dut_rf[pre_wr] = pre_wd;
         wlog.push_back(pre_wr);
      end
      if (rst) begin
         m_rd.delete(); m_d.delete();
         m_we = 1'b0; m_wr = '0; m_wd = '0;
      end else begin
         if (av) begin
            m_we = (ard != 0); m_wr = ard; m_wd = ad;
         end else if (m_rd.size() > 0) begin
            m_we = 1'b1; m_wr = m_rd.pop_front(); m_wd = m_d.pop_front();
         end else begin
            m_we = 1'b0;
         end
         if (mv && !full && mrd != 0) begin
            m_rd.push_back(mrd); m_d.push_back(md);
         end
      end
      #1;
      check("write_enable", write_enable, m_we);
      check("fifo_count", fifo_count, m_rd.size());
      if (m_we || rst) begin
         check("write_reg", write_reg, m_wr);
         check("write_data", write_data, m_wd);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      int pushed;
      foreach (dut_rf[i]) dut_rf[i] = '0;
      reset = 1'b1; alu_valid = 0; alu_rd = 0; alu_data = 0;
      mem_valid = 0; mem_rd = 0; mem_data = 0; query_reg = 0;
      repeat (2) @(posedge clk);
      step(0, 0, 0, 0, 0, 0, 1);
      check("rst_ready", mem_ready, 1);
      check("rst_we", write_enable, 0);
      check("rst_count", fifo_count, 0);
      idle(2);

      // ALU only
      step(1, 5'd5, 32'hDEADBEEF, 0, 0, 0, 0);
      check("alu_we", write_enable, 1);
      check("alu_wr", write_reg, 5);
      idle(1);
      check("alu_rf5", dut_rf[5], 32'hDEADBEEF);

      // Memory result while idle
      step(0, 0, 0, 1, 5'd7, 32'h1234, 0);
      check("mem_e_we", write_enable, 0);
      idle(1);
      check("mem_e1_we", write_enable, 1);
      check("mem_e1_wr", write_reg, 7);
      idle(2);
      check("mem_rf7", dut_rf[7], 32'h1234);

      // Contention: 6 ALU results while 5 memory results are offered
      wlog.delete();
      pushed = 0;
      for (int i = 0; i < 6; i++) begin
         logic acc;
         acc = (pushed < 5) && (m_rd.size() < DEPTH);
         step(1, 5'(i + 1), 32'hA000 + i, pushed < 5, 5'(10 + pushed), 32'hB000 + pushed, 0);
         if (acc) pushed++;
      end
      check("cont_pushed", pushed, 4);
      check("cont_ready_low", mem_ready, 0);
      idle(6);
      check("cont_nwrites", wlog.size(), 10);
      for (int i = 0; i < 10 && i < wlog.size(); i++)
         check("cont_order", wlog[i], (i < 6) ? 5'(i + 1) : 5'(4 + i));

      // rd=0 from both sources
      for (int i = 0; i < 4; i++) begin
         step(1, 0, 32'hFFFF0000, 1, 0, 32'h0000FFFF, 0);
         check("zero_count", fifo_count, 0);
         check("zero_we", write_enable, 0);
      end
      idle(2);
      check("zero_rf0", dut_rf[0], 0);

      // Query on a queued memory destination
      force_q = 9;
      step(0, 0, 0, 1, 5'd9, 32'h99, 0);
      check("q_queued", query_pending, 1);
      idle(1);
      check("q_writing", query_pending, 1);
      idle(1);
      check("q_done", query_pending, 0);
      force_q = 0;
      step(1, 0, 0, 1, 0, 0, 0);
      check("q_zero", query_pending, 0);
      force_q = -1;

      // Reset with three entries in flight (ALU x0 traffic blocks draining)
      for (int i = 0; i < 3; i++) step(1, 0, 0, 1, 5'(20 + i), 32'hC0 + i, 0);
      check("mid_count3", fifo_count, 3);
      step(1, 0, 0, 1, 5'd30, 32'h30, 1);
      check("mid_count", fifo_count, 0);
      check("mid_we", write_enable, 0);
      check("mid_ready", mem_ready, 1);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         logic av;
         logic mv;
         av = ($urandom_range(0, 9) < 4);
         mv = ($urandom_range(0, 9) < 6);
         step(av, 5'($urandom_range(0, 31)), $urandom, mv, 5'($urandom_range(0, 31)), $urandom,
              $urandom_range(0, 63) == 0);
      end
      idle(8);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
